// File: rtl/transaction_sequencer_pkg.sv
// Shared encodings for the coin transaction sequencer: FSM states, step
// select one-hots, memory word tags and fail codes.
package transaction_sequencer_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_AMT, S_WAIT_KEY, S_RD_P1, S_VER_AMT, S_RD_KEY, S_VER_KEY,
    S_RD_P2, S_COMMIT, S_WR_P1, S_WR_P2, S_DONE, S_FAIL
  } state_t;

  localparam logic [2:0] PROC_NONE   = 3'b000;
  localparam logic [2:0] PROC_AMT    = 3'b001;
  localparam logic [2:0] PROC_KEY    = 3'b010;
  localparam logic [2:0] PROC_COMMIT = 3'b100;

  localparam logic [2:0] TAG_P1 = 3'b101;
  localparam logic [2:0] TAG_P2 = 3'b110;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_AMT     = 2'b01;
  localparam logic [1:0] FC_KEY     = 2'b10;
  localparam logic [1:0] FC_TIMEOUT = 2'b11;

  function automatic logic is_read(state_t s);
    return (s == S_RD_P1) || (s == S_RD_KEY) || (s == S_RD_P2);
  endfunction

  function automatic logic is_verify(state_t s);
    return (s == S_VER_AMT) || (s == S_VER_KEY) || (s == S_COMMIT);
  endfunction

endpackage

// File: rtl/transaction_sequencer_step_timer.sv
// Step watchdog: counts enabled cycles from a clear, flags expiry at
// TIMEOUT-1 and holds there until cleared.
module step_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 1'b1;
  end

  assign expired = (cnt == LAST);
endmodule

// File: rtl/transaction_sequencer.sv
// Coin transfer sequencer: captures amount/key, fetches balances and key,
// steps the datapath and writes both balances back. TX_STATS_EN adds counters.
module transaction_sequencer
  import transaction_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] P1_ADDR  = ADDR_W'(0),
  parameter logic [ADDR_W-1:0] P2_ADDR  = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] KEY_ADDR = ADDR_W'(2),
  parameter int                TIMEOUT  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              amount_valid,
  input  logic              key_valid,
  input  logic              done_step,
  input  logic [10:0]       p1_amount_out,
  input  logic [10:0]       p2_amount_out,
  output logic              load_amount,
  output logic              load_key,
  output logic [2:0]        process,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wren,
  output logic [10:0]       mem_wdata,
  output logic              busy,
  output logic              tx_ok,
  output logic              tx_fail,
`ifdef TX_STATS_EN
  output logic [7:0]        ok_count,
  output logic [7:0]        fail_count,
`endif
  output logic [1:0]        fail_code
);

  state_t     state, next;
  logic       rd_hold;
  logic       expired;
  logic [1:0] fail_sel;

  step_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (next != state),
    .enable  (is_verify(state)),
    .expired (expired)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  // Synchronous-read memory: each read state dwells two cycles on its address.
  always_ff @(posedge clock) begin
    if (reset) rd_hold <= 1'b0;
    else       rd_hold <= is_read(state) && !rd_hold;
  end

  always_comb begin
    next     = state;
    fail_sel = FC_NONE;
    case (state)
      S_IDLE:     if (start) next = S_WAIT_AMT;
      S_WAIT_AMT: if (amount_valid) next = S_WAIT_KEY;
      S_WAIT_KEY: if (key_valid) next = S_RD_P1;
      S_RD_P1:    if (rd_hold) next = S_VER_AMT;
      S_VER_AMT: begin
        fail_sel = FC_AMT;
        if (done_step)    next = S_RD_KEY;
        else if (expired) next = S_FAIL;
      end
      S_RD_KEY:   if (rd_hold) next = S_VER_KEY;
      S_VER_KEY: begin
        fail_sel = FC_KEY;
        if (done_step)    next = S_RD_P2;
        else if (expired) next = S_FAIL;
      end
      S_RD_P2:    if (rd_hold) next = S_COMMIT;
      S_COMMIT: begin
        fail_sel = FC_TIMEOUT;
        if (done_step)    next = S_WR_P1;
        else if (expired) next = S_FAIL;
      end
      S_WR_P1:    next = S_WR_P2;
      S_WR_P2:    next = S_DONE;
      S_DONE:     next = S_IDLE;
      S_FAIL:     next = S_IDLE;
      default:    next = S_IDLE;
    endcase
  end

  always_comb begin
    load_amount = (state == S_WAIT_AMT) && amount_valid && !reset;
    load_key    = (state == S_WAIT_KEY) && key_valid && !reset;
    process     = PROC_NONE;
    mem_addr    = P1_ADDR;
    mem_wren    = 1'b0;
    mem_wdata   = '0;
    busy        = (state != S_IDLE);
    tx_ok       = (state == S_DONE);
    tx_fail     = (state == S_FAIL);
    case (state)
      S_RD_P1, S_VER_AMT: mem_addr = P1_ADDR;
      S_RD_KEY, S_VER_KEY: mem_addr = KEY_ADDR;
      S_RD_P2, S_COMMIT:  mem_addr = P2_ADDR;
      S_WR_P1: begin
        mem_addr  = P1_ADDR;
        mem_wren  = 1'b1;
        mem_wdata = p1_amount_out;
      end
      S_WR_P2: begin
        mem_addr  = P2_ADDR;
        mem_wren  = 1'b1;
        mem_wdata = p2_amount_out;
      end
      default: ;
    endcase
    case (state)
      S_VER_AMT: process = PROC_AMT;
      S_VER_KEY: process = PROC_KEY;
      S_COMMIT:  process = PROC_COMMIT;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)                                      fail_code <= FC_NONE;
    else if (state == S_IDLE && start)              fail_code <= FC_NONE;
    else if (next == S_FAIL && state != S_FAIL)     fail_code <= fail_sel;
  end

`ifdef TX_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      ok_count   <= '0;
      fail_count <= '0;
    end else begin
      if (tx_ok && ok_count != 8'hFF)     ok_count   <= ok_count + 8'd1;
      if (tx_fail && fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_transaction_sequencer.sv
// Bench: each transaction is expanded into a per-cycle timeline of inputs and
// expected outputs from the sequencing rules, then replayed and compared.
module tb_transaction_sequencer;
  localparam int TO = 16;

  logic        clock = 0, reset = 1, start = 0, amount_valid = 0, key_valid = 0, done_step = 0;
  logic [10:0] p1_amount_out = '0, p2_amount_out = '0;
  logic        load_amount, load_key, mem_wren, busy, tx_ok, tx_fail;
  logic [2:0]  process;
  logic [4:0]  mem_addr;
  logic [10:0] mem_wdata;
  logic [1:0]  fail_code;
`ifdef TX_STATS_EN
  logic [7:0]  ok_count, fail_count;
`endif

  transaction_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .amount_valid(amount_valid),
    .key_valid(key_valid), .done_step(done_step), .p1_amount_out(p1_amount_out),
    .p2_amount_out(p2_amount_out), .load_amount(load_amount), .load_key(load_key),
    .process(process), .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
    .busy(busy), .tx_ok(tx_ok), .tx_fail(tx_fail),
`ifdef TX_STATS_EN
    .ok_count(ok_count), .fail_count(fail_count),
`endif
    .fail_code(fail_code)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic start, av, kv, done, rst;
    logic [10:0] p1o, p2o;
    logic busy, la, lk, wren, chk_addr, ok, fail;
    logic [2:0] proc;
    logic [4:0] addr;
    logic [10:0] wdata;
    logic [1:0] fcode;
  } cyc_t;

  cyc_t tl[$];
  cyc_t cur;
  bit   chk_en = 0;
  int   errors = 0, checks = 0, cyc = 0;
  logic [1:0]  m_fcode = 2'b00;
  int   m_ok = 0, m_fail = 0;
  logic [10:0] b_p1o, b_p2o;
  int   n_la = 0, n_lk = 0, n_amt = 0, n_key = 0, n_wren = 0, n_ok = 0, n_fail = 0;
  logic [10:0] mem [0:31];

  always @(posedge clock) if (mem_wren) mem[mem_addr] <= mem_wdata;

  task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clock) if (chk_en) begin
    cyc++;
    cmp("busy", 16'(busy), 16'(cur.busy));
    cmp("load_amount", 16'(load_amount), 16'(cur.la));
    cmp("load_key", 16'(load_key), 16'(cur.lk));
    cmp("process", 16'(process), 16'(cur.proc));
    cmp("mem_wren", 16'(mem_wren), 16'(cur.wren));
    cmp("tx_ok", 16'(tx_ok), 16'(cur.ok));
    cmp("tx_fail", 16'(tx_fail), 16'(cur.fail));
    cmp("fail_code", 16'(fail_code), 16'(cur.fcode));
    if (cur.chk_addr) cmp("mem_addr", 16'(mem_addr), 16'(cur.addr));
    if (cur.wren) cmp("mem_wdata", 16'(mem_wdata), 16'(cur.wdata));
    n_la += int'(load_amount); n_lk += int'(load_key); n_wren += int'(mem_wren);
    n_ok += int'(tx_ok); n_fail += int'(tx_fail);
    n_amt += int'(process == 3'b001); n_key += int'(process == 3'b010);
  end

  function automatic cyc_t blank();
    cyc_t c;
    c = '{default: '0};
    c.busy = 1; c.fcode = m_fcode;
    return c;
  endfunction

  task automatic push(input cyc_t c);
    c.p1o = b_p1o; c.p2o = b_p2o;
    tl.push_back(c);
  endtask

  task automatic idle(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank(); c.busy = 0; c.chk_addr = 1; c.addr = 5'd0;
      c.av = 1'($urandom); c.kv = 1'($urandom); c.done = 1'($urandom);
      push(c);
    end
  endtask

  task automatic rd(input logic [4:0] a);
    cyc_t c;
    for (int i = 0; i < 2; i++) begin
      c = blank(); c.chk_addr = 1; c.addr = a;
      c.av = 1'($urandom); c.kv = 1'($urandom); c.done = 1'($urandom);
      push(c);
    end
  endtask

  task automatic step(input logic [2:0] pr, input int d, input logic [1:0] code, output bit ok);
    cyc_t c;
    if (d >= 0) begin
      for (int i = 0; i < d; i++) begin c = blank(); c.proc = pr; push(c); end
      c = blank(); c.proc = pr; c.done = 1; push(c);
      ok = 1;
    end else begin
      for (int i = 0; i < TO; i++) begin c = blank(); c.proc = pr; push(c); end
      m_fcode = code;
      c = blank(); c.fail = 1; push(c);
      m_fail++;
      ok = 0;
    end
  endtask

  // d<0 means done_step never comes in that step.
  task automatic build_tx(input int a_gap, input int k_gap, input bit stray_kv, input bit stray_start,
                          input int d0, input int d1, input int d2, input bit rst_commit,
                          input logic [10:0] p1o, input logic [10:0] p2o);
    cyc_t c;
    bit ok;
    b_p1o = p1o; b_p2o = p2o;
    c = blank(); c.busy = 0; c.start = 1; c.chk_addr = 1; c.addr = 5'd0; push(c);
    m_fcode = 2'b00;
    for (int i = 0; i <= a_gap; i++) begin
      c = blank();
      if (i == 0) begin c.kv = stray_kv; c.start = stray_start; end
      if (i == a_gap) begin c.av = 1; c.la = 1; end
      push(c);
    end
    for (int i = 0; i <= k_gap; i++) begin
      c = blank();
      if (i == 0) c.start = stray_start;
      c.av = stray_kv;
      if (i == k_gap) begin c.kv = 1; c.lk = 1; end
      push(c);
    end
    rd(5'd0);
    step(3'b001, d0, 2'b01, ok);
    if (!ok) begin idle(1); return; end
    rd(5'd2);
    step(3'b010, d1, 2'b10, ok);
    if (!ok) begin idle(1); return; end
    rd(5'd1);
    if (rst_commit) begin
      for (int i = 0; i < 2; i++) begin c = blank(); c.proc = 3'b100; push(c); end
      c = blank(); c.proc = 3'b100; c.rst = 1; push(c);
      m_fcode = 2'b00; m_ok = 0; m_fail = 0;
      idle(2);
      return;
    end
    step(3'b100, d2, 2'b11, ok);
    if (!ok) begin idle(1); return; end
    c = blank(); c.wren = 1; c.chk_addr = 1; c.addr = 5'd0; c.wdata = p1o; push(c);
    c = blank(); c.wren = 1; c.chk_addr = 1; c.addr = 5'd1; c.wdata = p2o; push(c);
    c = blank(); c.ok = 1; push(c);
    m_ok++;
    idle(1);
  endtask

  task automatic play();
    cyc_t c;
    while (tl.size() > 0) begin
      c = tl.pop_front();
      @(posedge clock); #1;
      start = c.start; amount_valid = c.av; key_valid = c.kv; done_step = c.done;
      reset = c.rst; p1_amount_out = c.p1o; p2_amount_out = c.p2o;
      cur = c; chk_en = 1;
    end
  endtask

  function automatic int rdelay();
    return ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TO - 1));
  endfunction

  initial begin
    int s_amt, s_key, s_wren, s_fail, s_ok, s_la, s_lk;
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem[0] = 11'h514; mem[1] = 11'h603;
    reset = 1;
    repeat (2) @(posedge clock);
    b_p1o = '0; b_p2o = '0;
    idle(3); play();

    // Happy path: 20 - 5 -> 15, 3 + 5 -> 8, tags preserved.
    s_wren = n_wren; s_ok = n_ok;
    build_tx(1, 1, 0, 0, 3, 3, 3, 0, 11'b101_00001111, 11'b110_00001000); play();
    cmp("happy_mem_p1", 16'(mem[0]), 16'h050F);
    cmp("happy_mem_p2", 16'(mem[1]), 16'h0608);
    cmp("happy_wren_cnt", 16'(n_wren - s_wren), 16'd2);
    cmp("happy_ok_cnt", 16'(n_ok - s_ok), 16'd1);

    // Insufficient funds: verify-amount never passes.
    s_amt = n_amt; s_wren = n_wren; s_fail = n_fail;
    build_tx(0, 0, 0, 0, -1, 0, 0, 0, 11'h000, 11'h000); play();
    cmp("insuf_amt_cycles", 16'(n_amt - s_amt), 16'd16);
    cmp("insuf_wren_cnt", 16'(n_wren - s_wren), 16'd0);
    cmp("insuf_fail_cnt", 16'(n_fail - s_fail), 16'd1);
    cmp("insuf_code", 16'(fail_code), 16'd1);

    // Wrong key.
    s_key = n_key; s_wren = n_wren;
    build_tx(2, 0, 0, 0, 2, -1, 0, 0, 11'h000, 11'h000); play();
    cmp("key_cycles", 16'(n_key - s_key), 16'd16);
    cmp("key_wren_cnt", 16'(n_wren - s_wren), 16'd0);
    cmp("key_code", 16'(fail_code), 16'd2);

    // Stray start and early key_valid are ignored; one load of each.
    s_la = n_la; s_lk = n_lk;
    build_tx(0, 2, 1, 1, 1, 1, 1, 0, 11'h5AA, 11'h655); play();
    cmp("robust_la_cnt", 16'(n_la - s_la), 16'd1);
    cmp("robust_lk_cnt", 16'(n_lk - s_lk), 16'd1);
    s_lk = n_lk;
    build_tx(2, 1, 1, 0, 0, 0, 0, 0, 11'h501, 11'h602); play();
    cmp("robust2_lk_cnt", 16'(n_lk - s_lk), 16'd1);

    // Reset during COMMIT: idle next cycle, no write.
    s_wren = n_wren;
    build_tx(1, 1, 0, 0, 0, 0, 0, 1, 11'h7FF, 11'h7FF); play();
    cmp("rst_wren_cnt", 16'(n_wren - s_wren), 16'd0);
    cmp("rst_mem_p1", 16'(mem[0]), 16'h0501);

    build_tx(0, 0, 0, 0, 0, 0, 0, 0, 11'h510, 11'h610); play();
    build_tx(1, 0, 0, 0, 5, 2, 15, 0, 11'h511, 11'h611); play();
    build_tx(0, 1, 0, 0, 4, 4, -1, 0, 11'h000, 11'h000); play();
    cmp("commit_timeout_code", 16'(fail_code), 16'd3);
`ifdef TX_STATS_EN
    cmp("stats_ok_2", 16'(ok_count), 16'd2);
    cmp("stats_fail_1", 16'(fail_count), 16'd1);
`endif

    for (int t = 0; t < 25; t++) begin
      build_tx($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
               rdelay(), rdelay(), rdelay(), 0, 11'($urandom), 11'($urandom));
      play();
    end

`ifdef TX_STATS_EN
    cmp("stats_ok_model", 16'(ok_count), 16'((m_ok > 255) ? 255 : m_ok));
    cmp("stats_fail_model", 16'(fail_count), 16'((m_fail > 255) ? 255 : m_fail));
    for (int t = 0; t < 300; t++) begin
      build_tx(0, 0, 0, 0, 0, 0, 0, 0, 11'h520, 11'h620); play();
    end
    cmp("stats_ok_sat", 16'(ok_count), 16'd255);
`endif

    @(posedge clock); #1; chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
